pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, meaning: PC width in bits; legal range 16..32.
REQ-002 Parameter RESET_VECTOR, default 32'hE0000000, meaning: PC value after reset, truncated to ADDR_WIDTH.
REQ-003 Parameter VECTOR_BASE_HI, default 32'hE0000000, meaning: vector base used when vector_bit=0.
REQ-004 Parameter VECTOR_BASE_LO, default 32'hC0000000, meaning: vector base used when vector_bit=1.
REQ-005 Parameter NUM_VECTORS, default 4, meaning: count of handler entries; power of 2, at least 2; VW = clog2(NUM_VECTORS).
REQ-006 Parameter RAS_DEPTH, default 4, meaning: return-address-stack entries; power of 2, at least 2.
REQ-007 clock  in  1  clock; all state changes on the rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 write_enable  in  1  PC update strobe; when 0, no PC, RAS or flag change except clearing of pulse outputs.
REQ-010 source  in  3  next-PC select: 0 INCREMENT, 1 ADD_OFFSET, 2 EXPLICIT, 3 VECTOR, 4 RETURN; 5-7 HOLD.
REQ-011 word_offset  in  ADDR_WIDTH-2  signed word offset for ADD_OFFSET.
REQ-012 explicit_value  in  ADDR_WIDTH  target for EXPLICIT, and fallback target for RETURN on an empty stack.
REQ-013 vector_bit  in  1  PSW vector bit; selects the vector base.
REQ-014 vector_index  in  VW  handler number for VECTOR.
REQ-015 push_return  in  1  call marker; with write_enable=1, pushes PC+4 onto the RAS.
REQ-016 program_counter  out  ADDR_WIDTH  current PC.
REQ-017 ras_empty / ras_full  out  1 each  stack occupancy is 0 / RAS_DEPTH.
REQ-018 ras_overflow  out  1  sticky; set when a push overwrites the oldest entry.
REQ-019 misaligned  out  1  one-cycle pulse; asserted the cycle after an EXPLICIT or fallback load whose low 2 bits are nonzero.
REQ-020 ras_underflow  out  1  one-cycle pulse; asserted the cycle after a RETURN taken on an empty stack.

Function
REQ-021 INCREMENT: PC <= PC+4.
REQ-022 ADD_OFFSET: PC <= PC + sign_extend({word_offset,2'b00}).
REQ-023 EXPLICIT: PC <= {explicit_value[AW-1:2],2'b00}.
REQ-024 VECTOR: PC <= base + 4*(vector_index+1); base is VECTOR_BASE_LO if vector_bit=1, else VECTOR_BASE_HI; defaults give 0xE0000004 and 0xC0000008-style entries.
REQ-025 All PC arithmetic is modulo 2^ADDR_WIDTH, with no overflow indication; the PC low 2 bits are always 0.
REQ-026 RETURN, nonempty stack: PC <= top entry; occupancy decrements.
REQ-027 RETURN, empty stack: PC <= aligned explicit_value; ras_underflow pulses; occupancy stays 0.
REQ-028 HOLD: PC unchanged; push_return still honoured.
REQ-029 Push stores the pre-update PC+4 and is independent of source.
REQ-030 Push on a full stack: the entry is written at the oldest slot (circular), occupancy stays RAS_DEPTH, ras_overflow <= 1.
REQ-031 Push and RETURN on a nonempty stack in the same cycle: PC <= old top, the top is replaced by PC+4, occupancy is unchanged.
REQ-032 Push and RETURN on an empty stack in the same cycle: follow REQ-027, then push, so occupancy becomes 1.
REQ-033 Latency: every update is visible on program_counter and the flags one cycle after the strobe edge; there is no combinational path from inputs to outputs.
REQ-034 ras_overflow clears only on reset.

Reset
REQ-035 On reset: PC <= RESET_VECTOR; occupancy <= 0; stack pointer <= 0; ras_overflow, misaligned and ras_underflow <= 0; ras_empty=1, ras_full=0.
REQ-036 Reset has priority over write_enable in the same cycle; RAS storage contents are not reset.
REQ-037 Reset asserted mid-sequence discards all stack state, so the next RETURN is treated as empty.

Structure
REQ-038 The source encodings (INCREMENT..RETURN, HOLD) and SRC_WIDTH=3 reside in a shared package, pc_pkg, used by the control unit.
REQ-039 The stack is a separate sub-module, return_address_stack (parameters WIDTH, DEPTH), with push, pop, top, empty, full and overflow ports; PC selection logic remains in pc_sequencer.

Verification
REQ-040 Reset, then 3 INCREMENT strobes -> PC = 0xE0000000, 0xE0000004, 0xE0000008, 0xE000000C.
REQ-041 PC=0xE0000010, ADD_OFFSET with word_offset=-4 -> 0xE0000000; PC=0xFFFFFFFC, INCREMENT -> 0x00000000.
REQ-042 VECTOR index 1 with vector_bit=0 -> 0xE0000008; index 0 with vector_bit=1 -> 0xC0000004; EXPLICIT 0x1003 -> PC=0x1000, misaligned pulses for 1 cycle.
REQ-043 Five EXPLICIT+push calls from PCs A..E, then 4 RETURNs -> targets E+4, D+4, C+4, B+4; ras_overflow=1; the fifth RETURN takes explicit_value and pulses ras_underflow.
REQ-044 Occupancy 2, push+RETURN together at PC=0x100 -> PC=old top, new top=0x104, ras_full/ras_empty unchanged.
REQ-045 Reset asserted together with write_enable and push at occupancy 3 -> PC=RESET_VECTOR, ras_empty=1, ras_overflow=0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer.
//   SRC_WIDTH  : width of the next-PC select field
//   pc_src_e   : next-PC select encodings; codes above SRC_RETURN behave as SRC_HOLD
package pc_pkg;

    localparam int SRC_WIDTH = 3;

    typedef enum logic [SRC_WIDTH-1:0] {
        SRC_INCREMENT  = 3'd0,
        SRC_ADD_OFFSET = 3'd1,
        SRC_EXPLICIT   = 3'd2,
        SRC_VECTOR     = 3'd3,
        SRC_RETURN     = 3'd4,
        SRC_HOLD       = 3'd5
    } pc_src_e;

endpackage

// File: rtl/return_address_stack.sv
// Circular return-address stack.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   push         : write push_data as the new top
//   pop          : discard the top entry (ignored when empty)
//   push_data    : address to store
//   top          : current top entry (undefined when empty)
//   empty, full  : occupancy is 0 / DEPTH
//   overflow     : sticky, set when a push overwrites the oldest entry
module return_address_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full,
    output logic             overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [PW-1:0]    sp_q, sp_d;
    logic [PW-1:0]    top_idx;
    logic [PW-1:0]    wr_idx;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             wr_en;
    logic             do_pop;

    // sp_q is the next free slot; once the stack is full it wraps onto the
    // oldest entry, so a push at full naturally overwrites that entry.
    assign top_idx  = sp_q - PW'(1);
    assign top      = stack_q[top_idx];
    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_COUNT);
    assign overflow = overflow_q;

    always_comb begin
        sp_d       = sp_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        wr_idx     = sp_q;
        do_pop     = pop && !empty;
        if (push && do_pop) begin
            // Simultaneous pop and push: replace the top in place.
            wr_en  = 1'b1;
            wr_idx = top_idx;
        end else if (push) begin
            wr_en = 1'b1;
            sp_d  = sp_q + PW'(1);
            if (full) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end else if (do_pop) begin
            sp_d    = top_idx;
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sp_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            sp_q       <= sp_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately left out of reset; occupancy alone decides validity.
    always_ff @(posedge clock) begin
        if (wr_en && !reset) begin
            stack_q[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with vectoring and a return-address stack.
//   clock, reset    : rising-edge clock, synchronous active-high reset
//   write_enable    : PC update strobe
//   source          : next-PC select (pc_pkg::pc_src_e)
//   word_offset     : signed word offset for SRC_ADD_OFFSET
//   explicit_value  : target for SRC_EXPLICIT and for SRC_RETURN on an empty stack
//   vector_bit      : selects VECTOR_BASE_LO (1) or VECTOR_BASE_HI (0)
//   vector_index    : handler number for SRC_VECTOR
//   push_return     : push PC+4 onto the return stack
//   program_counter : current PC
//   ras_empty/full  : stack occupancy flags
//   ras_overflow    : sticky stack overwrite flag
//   misaligned      : pulse after a load of an address with nonzero low bits
//   ras_underflow   : pulse after a return taken on an empty stack
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 32,
    parameter logic [31:0] RESET_VECTOR   = 32'hE0000000,
    parameter logic [31:0] VECTOR_BASE_HI = 32'hE0000000,
    parameter logic [31:0] VECTOR_BASE_LO = 32'hC0000000,
    parameter int          NUM_VECTORS    = 4,
    parameter int          RAS_DEPTH      = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           write_enable,
    input  logic [SRC_WIDTH-1:0]           source,
    input  logic [ADDR_WIDTH-3:0]          word_offset,
    input  logic [ADDR_WIDTH-1:0]          explicit_value,
    input  logic                           vector_bit,
    input  logic [$clog2(NUM_VECTORS)-1:0] vector_index,
    input  logic                           push_return,
    output logic [ADDR_WIDTH-1:0]          program_counter,
    output logic                           ras_empty,
    output logic                           ras_full,
    output logic                           ras_overflow,
    output logic                           misaligned,
    output logic                           ras_underflow
);

    localparam int AW = ADDR_WIDTH;
    localparam int OW = AW - 2;
    localparam int VW = $clog2(NUM_VECTORS);

    localparam logic [AW-1:0] RESET_PC = {RESET_VECTOR[AW-1:2], 2'b00};
    localparam logic [AW-1:0] BASE_HI  = {VECTOR_BASE_HI[AW-1:2], 2'b00};
    localparam logic [AW-1:0] BASE_LO  = {VECTOR_BASE_LO[AW-1:2], 2'b00};
    localparam logic [AW-1:0] PC_STEP  = AW'(4);

    logic [AW-1:0] pc_q, pc_d;
    logic          misaligned_q, misaligned_d;
    logic          underflow_q, underflow_d;
    logic [AW-1:0] return_addr;
    logic [AW-1:0] aligned_explicit;
    logic [AW-1:0] vector_offset;
    logic [AW-1:0] ras_top;
    logic          ras_push;
    logic          ras_pop;

    // Handler n lives one word past n words from the base, hence index+1.
    assign vector_offset    = {OW'(vector_index) + OW'(1), 2'b00};
    assign return_addr      = pc_q + PC_STEP;
    assign aligned_explicit = {explicit_value[AW-1:2], 2'b00};

    // The stack only sees a pop on a return; it ignores the pop when empty,
    // which lets a same-cycle push on an empty stack land as a plain push.
    always_comb begin
        pc_d         = pc_q;
        misaligned_d = 1'b0;
        underflow_d  = 1'b0;
        ras_push     = write_enable && push_return;
        ras_pop      = 1'b0;
        if (write_enable) begin
            case (source)
                SRC_INCREMENT:  pc_d = return_addr;
                SRC_ADD_OFFSET: pc_d = pc_q + {word_offset, 2'b00};
                SRC_EXPLICIT: begin
                    pc_d         = aligned_explicit;
                    misaligned_d = |explicit_value[1:0];
                end
                SRC_VECTOR:     pc_d = (vector_bit ? BASE_LO : BASE_HI) + vector_offset;
                SRC_RETURN: begin
                    ras_pop = 1'b1;
                    if (ras_empty) begin
                        pc_d         = aligned_explicit;
                        misaligned_d = |explicit_value[1:0];
                        underflow_d  = 1'b1;
                    end else begin
                        pc_d = ras_top;
                    end
                end
                default:        pc_d = pc_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            misaligned_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            misaligned_q <= misaligned_d;
            underflow_q  <= underflow_d;
        end
    end

    return_address_stack #(
        .WIDTH (AW),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock     (clock),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (return_addr),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .overflow  (ras_overflow)
    );

    assign program_counter = pc_q;
    assign misaligned      = misaligned_q;
    assign ras_underflow   = underflow_q;

endmodule
